// File: rtl/pdm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pdm_pkg
// Purpose  : Shared definitions for the PDM duty path: default slew
//            parameters, duty-slew state encoding and a helper that forms
//            the unsigned distance between two duty values.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pdm_pkg;

  // 20 kHz update rate at a 50 MHz system clock.
  localparam int unsigned c_TICK_DIV_DEFAULT = 2500;
  localparam logic [15:0] c_STEP_DEFAULT     = 16'h0040;

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_HOLD = 2'd1;
  localparam logic [1:0] c_ST_RAMP = 2'd2;

  typedef enum logic [1:0] {
    IDLE = c_ST_IDLE,
    HOLD = c_ST_HOLD,
    RAMP = c_ST_RAMP
  } state_e;

  // |a - b| at 17 bits so the subtraction can never wrap.
  function automatic logic [16:0] abs_diff17(input logic [15:0] a,
                                             input logic [15:0] b);
    logic [16:0] a17;
    logic [16:0] b17;
    a17 = {1'b0, a};
    b17 = {1'b0, b};
    return (a17 >= b17) ? (a17 - b17) : (b17 - a17);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running modulo-TICK_DIV counter that raises tick for one
//            cycle each time the count reaches TICK_DIV-1.
// Ports    : clk  - system clock
//            rst  - synchronous active-high reset
//            clr  - holds the count at 0 while high
//            tick - one-cycle pulse when the count equals TICK_DIV-1
// Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
  parameter int unsigned TICK_DIV = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [15:0] c_LAST = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (cnt_q == c_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign tick = (cnt_q == c_LAST);

endmodule
`default_nettype wire

// File: rtl/duty_slew.sv
`default_nettype none
// ============================================================================
// Module   : duty_slew
// Purpose  : Slew-rate limiter for the PDM modulator duty input. Accepts a
//            target duty and walks the registered duty toward it by at most
//            STEP per update tick, landing exactly on the target.
// Ports    : clk      - 50 MHz system clock
//            rst      - synchronous active-high reset
//            enable   - drive enable; low forces duty to 0 immediately
//            tgt_duty - unsigned target duty
//            tgt_vld  - tgt_duty valid
//            tgt_rdy  - target accepted this cycle when high with tgt_vld
//            duty     - registered duty output
//            at_tgt   - duty has settled on the accepted target (HOLD)
//            busy     - a ramp is in progress (RAMP)
// Revision : 1.0  initial release
// ============================================================================
module duty_slew
  import pdm_pkg::*;
#(
  parameter int unsigned TICK_DIV = c_TICK_DIV_DEFAULT,
  parameter logic [15:0] STEP     = c_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] tgt_duty,
  input  logic        tgt_vld,
  output logic        tgt_rdy,
  output logic [15:0] duty,
  output logic        at_tgt,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [15:0] duty_q, duty_d;
  logic [15:0] tgt_q, tgt_d;

  logic        w_tick;
  logic        w_clr;
  logic [16:0] w_diff;
  logic        w_up;

  // The counter only runs while driving, so the first update after enable
  // always lands a full TICK_DIV period after the count restarts.
  assign w_clr = (state_q == IDLE) || !enable;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_clr),
    .tick (w_tick)
  );

  assign w_diff = abs_diff17(tgt_q, duty_q);
  assign w_up   = (tgt_q > duty_q);

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    if (!enable) begin
      // Abrupt shutoff: no ramp-down.
      state_d = IDLE;
      duty_d  = '0;
      tgt_d   = '0;
    end else begin
      // The ramp below reads the registered tgt_q, so a target accepted on a
      // tick cycle only steers the following tick.
      if (state_q != IDLE && tgt_vld) begin
        tgt_d = tgt_duty;
      end
      case (state_q)
        IDLE: state_d = HOLD;
        HOLD: begin
          if (tgt_q != duty_q) begin
            state_d = RAMP;
          end
        end
        RAMP: begin
          if (w_tick) begin
            if (w_diff <= {1'b0, STEP}) begin
              // Final step snaps onto the target, so no overshoot or wrap.
              duty_d  = tgt_q;
              state_d = HOLD;
            end else if (w_up) begin
              duty_d = duty_q + STEP;
            end else begin
              duty_d = duty_q - STEP;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
    end
  end

  assign tgt_rdy = (state_q != IDLE);
  assign at_tgt  = (state_q == HOLD);
  assign busy    = (state_q == RAMP);
  assign duty    = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_duty_slew.sv
`default_nettype none
// ============================================================================
// Module   : tb_duty_slew
// Purpose  : Directed self-checking bench for duty_slew with TICK_DIV = 4
//            and STEP = 16'h0100.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_duty_slew;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] tgt_duty;
  logic        tgt_vld;
  logic        tgt_rdy;
  logic [15:0] duty;
  logic        at_tgt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  duty_slew #(
    .TICK_DIV (4),
    .STEP     (16'h0100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .tgt_duty (tgt_duty),
    .tgt_vld  (tgt_vld),
    .tgt_rdy  (tgt_rdy),
    .duty     (duty),
    .at_tgt   (at_tgt),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic send_target(input logic [15:0] v);
    tgt_duty = v;
    tgt_vld  = 1'b1;
    step_clk();
    tgt_vld  = 1'b0;
  endtask

  task automatic wait_duty_change(output int cycles, output bit ok);
    logic [15:0] prev;
    prev   = duty;
    cycles = 0;
    ok     = 1'b0;
    while (cycles < 50 && !ok) begin
      step_clk();
      cycles++;
      if (duty !== prev) ok = 1'b1;
    end
  endtask

  task automatic ramp_to(input logic [15:0] v, output bit ok);
    int n;
    send_target(v);
    ok = 1'b0;
    n  = 0;
    while (n < 4000 && !ok) begin
      if (at_tgt === 1'b1 && duty === v) ok = 1'b1;
      else begin
        step_clk();
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; tgt_vld = 1'b1; tgt_duty = 16'h0FFF;
    step_clk();
    step_clk();
    total++; if (duty !== 16'h0000) begin bad++; $display("FAIL reset_duty got=%h exp=0000", duty); end
    total++; if (tgt_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", tgt_rdy); end
    total++; if (at_tgt !== 1'b0) begin bad++; $display("FAIL reset_at_tgt got=%b exp=0", at_tgt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0; enable = 1'b0; tgt_vld = 1'b0;
    step_clk();
  endtask

  task automatic test_ramp_up();
    int c; bit ok;
    enable = 1'b1;
    step_clk();
    total++; if (at_tgt !== 1'b1 || tgt_rdy !== 1'b1 || duty !== 16'h0000) begin
      bad++; $display("FAIL hold_entry got at=%b rdy=%b duty=%h exp 1 1 0000", at_tgt, tgt_rdy, duty); end
    send_target(16'h0300);
    wait_duty_change(c, ok);
    total++; if (!ok || c != 3 || duty !== 16'h0100 || busy !== 1'b1) begin
      bad++; $display("FAIL ramp_first got ok=%b cyc=%0d duty=%h busy=%b exp 1 3 0100 1", ok, c, duty, busy); end
    wait_duty_change(c, ok);
    total++; if (!ok || c != 4 || duty !== 16'h0200) begin
      bad++; $display("FAIL ramp_second got ok=%b cyc=%0d duty=%h exp 1 4 0200", ok, c, duty); end
    wait_duty_change(c, ok);
    total++; if (!ok || c != 4 || duty !== 16'h0300 || at_tgt !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL ramp_last got ok=%b cyc=%0d duty=%h at=%b busy=%b exp 1 4 0300 1 0", ok, c, duty, at_tgt, busy); end
    step_clk();
    total++; if (at_tgt !== 1'b1 || duty !== 16'h0300) begin
      bad++; $display("FAIL ramp_settled got at=%b duty=%h exp 1 0300", at_tgt, duty); end
  endtask

  task automatic test_snap_down();
    int c; bit ok; bit busy_seen;
    send_target(16'h0250);
    step_clk();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL snap_busy got=%b exp=1", busy); end
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'h0250 || at_tgt !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL snap_value got ok=%b duty=%h at=%b busy=%b exp 1 0250 1 0", ok, duty, at_tgt, busy); end
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step_clk();
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0 || duty !== 16'h0250) begin
      bad++; $display("FAIL snap_quiet got busy_seen=%b duty=%h exp 0 0250", busy_seen, duty); end
  endtask

  task automatic test_boundaries();
    int c; bit ok;
    ramp_to(16'hFF80, ok);
    total++; if (!ok) begin bad++; $display("FAIL reach_ff80 got duty=%h exp=ff80", duty); end
    send_target(16'hFFFF);
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'hFFFF) begin bad++; $display("FAIL top_no_wrap got duty=%h exp=ffff", duty); end
    step_clk();
    total++; if (duty !== 16'hFFFF || at_tgt !== 1'b1) begin
      bad++; $display("FAIL top_hold got duty=%h at=%b exp ffff 1", duty, at_tgt); end
    ramp_to(16'h0080, ok);
    total++; if (!ok) begin bad++; $display("FAIL reach_0080 got duty=%h exp=0080", duty); end
    send_target(16'h0000);
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'h0000 || at_tgt !== 1'b1) begin
      bad++; $display("FAIL bottom_no_underflow got duty=%h at=%b exp 0000 1", duty, at_tgt); end
  endtask

  task automatic test_retarget();
    int c; bit ok;
    send_target(16'h0800);
    for (int i = 0; i < 3; i++) wait_duty_change(c, ok);
    total++; if (duty !== 16'h0300) begin bad++; $display("FAIL retgt_start got duty=%h exp=0300", duty); end
    send_target(16'h0100);
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'h0200 || busy !== 1'b1) begin
      bad++; $display("FAIL retgt_rev1 got duty=%h busy=%b exp 0200 1", duty, busy); end
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'h0100 || at_tgt !== 1'b1) begin
      bad++; $display("FAIL retgt_rev2 got duty=%h at=%b exp 0100 1", duty, at_tgt); end
    // Target written during the tick cycle: that tick still uses 0500.
    send_target(16'h0500);
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'h0200) begin bad++; $display("FAIL tickcyc_pre got duty=%h exp=0200", duty); end
    step_clk(); step_clk(); step_clk();
    tgt_duty = 16'h0000; tgt_vld = 1'b1;
    step_clk();
    tgt_vld = 1'b0;
    total++; if (duty !== 16'h0300 || busy !== 1'b1) begin
      bad++; $display("FAIL tickcyc_old got duty=%h busy=%b exp 0300 1", duty, busy); end
    wait_duty_change(c, ok);
    total++; if (!ok || c != 4 || duty !== 16'h0200) begin
      bad++; $display("FAIL tickcyc_new got cyc=%0d duty=%h exp 4 0200", c, duty); end
    wait_duty_change(c, ok);
    wait_duty_change(c, ok);
    total++; if (!ok || duty !== 16'h0000 || at_tgt !== 1'b1) begin
      bad++; $display("FAIL tickcyc_end got duty=%h at=%b exp 0000 1", duty, at_tgt); end
  endtask

  task automatic test_shutoff();
    int c; bit ok; bit busy_seen;
    send_target(16'h0800);
    for (int i = 0; i < 4; i++) wait_duty_change(c, ok);
    total++; if (duty !== 16'h0400 || busy !== 1'b1) begin
      bad++; $display("FAIL off_start got duty=%h busy=%b exp 0400 1", duty, busy); end
    enable = 1'b0;
    step_clk();
    total++; if (duty !== 16'h0000 || tgt_rdy !== 1'b0 || at_tgt !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL off_idle got duty=%h rdy=%b at=%b busy=%b exp 0000 0 0 0", duty, tgt_rdy, at_tgt, busy); end
    enable = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step_clk();
      if (busy === 1'b1) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0 || duty !== 16'h0000 || at_tgt !== 1'b1) begin
      bad++; $display("FAIL off_target_cleared got busy_seen=%b duty=%h at=%b exp 0 0000 1", busy_seen, duty, at_tgt); end
    send_target(16'h0800);
    for (int i = 0; i < 4; i++) wait_duty_change(c, ok);
    total++; if (duty !== 16'h0400) begin bad++; $display("FAIL rst_start got duty=%h exp=0400", duty); end
    rst = 1'b1;
    step_clk();
    total++; if (duty !== 16'h0000 || tgt_rdy !== 1'b0 || at_tgt !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL rst_idle got duty=%h rdy=%b at=%b busy=%b exp 0000 0 0 0", duty, tgt_rdy, at_tgt, busy); end
    rst = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      if (busy === 1'b1 || duty !== 16'h0000) busy_seen = 1'b1;
    end
    total++; if (busy_seen !== 1'b0 || at_tgt !== 1'b1) begin
      bad++; $display("FAIL rst_no_residual got moved=%b at=%b exp 0 1", busy_seen, at_tgt); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_snap_down();
    test_boundaries();
    test_retarget();
    test_shutoff();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/duty_slew.md
DUTY_SLEW -- requirements
Module: duty_slew

Interface
REQ-001 Parameter TICK_DIV, default 2500, is the clk cycles per slew update (20 kHz at 50 MHz); legal range is 2 to 65535.
REQ-002 Parameter STEP, default 16'h0040, is the maximum unsigned duty change per update; legal range is 1 to 16'hFFFF.
REQ-003 Port clk, input, 1 bit, is the 50 MHz system clock; the block SHALL use a single clock.
REQ-004 Port rst, input, 1 bit, is a synchronous, active-high reset.
REQ-005 Port enable, input, 1 bit, is the drive enable; low forces the output to idle.
REQ-006 Port tgt_duty, input, 16 bits, is the unsigned target duty.
REQ-007 Port tgt_vld, input, 1 bit, marks that tgt_duty is valid.
REQ-008 Port tgt_rdy, output, 1 bit, means the block accepts a target this cycle.
REQ-009 Port duty, output, 16 bits, is the registered unsigned duty that feeds the PDM modulator duty input.
REQ-010 Port at_tgt, output, 1 bit, means duty equals the accepted target.
REQ-011 Port busy, output, 1 bit, means a ramp is in progress.

Function
REQ-012 The state machine SHALL have three states: IDLE, HOLD and RAMP; all outputs SHALL be registered or decoded from state only.
REQ-013 IDLE: duty is 0, tgt_q is 0, and the tick counter is held at 0; IDLE moves to HOLD on the first cycle enable is 1.
REQ-014 In any state, enable = 0 SHALL force the next state to IDLE, duty to 0 and tgt_q to 0 (abrupt shutoff, no ramp-down).
REQ-015 tgt_rdy SHALL be 1 in HOLD and RAMP and 0 in IDLE; tgt_vld && tgt_rdy loads tgt_q on that clock edge, and a new load overwrites any previous target.
REQ-016 The tick counter SHALL count 0 to TICK_DIV-1 and wrap while not in IDLE; tick is 1 for exactly one cycle when the count equals TICK_DIV-1.
REQ-017 HOLD moves to RAMP on the next cycle whenever tgt_q != duty.
REQ-018 RAMP, on a tick with d = |tgt_q - duty| computed at 17-bit width:
- if d <= STEP: duty <= tgt_q and the next state is HOLD;
- else: duty <= duty + STEP or duty - STEP toward tgt_q, and the state stays RAMP.
REQ-019 Duty arithmetic SHALL never wrap: duty stays within 0 to 16'hFFFF, and the final step always lands exactly on tgt_q.
REQ-020 If a target is accepted in the same cycle as a tick, the tick SHALL use the old tgt_q; the new target takes effect from the next tick.
REQ-021 A retarget during RAMP SHALL reverse or extend the ramp at the next tick with no idle cycle; if the new tgt_q equals duty, RAMP moves to HOLD on the next tick with duty unchanged.
REQ-022 at_tgt = (state == HOLD) and busy = (state == RAMP).
REQ-023 duty SHALL change only on the cycle after a tick or on entry to IDLE, giving a latency of 1 clk from tick to duty.

Reset
REQ-024 rst = 1, sampled on a clk rising edge, SHALL give state IDLE, duty 0, tgt_q 0, counter 0, tgt_rdy 0, at_tgt 0 and busy 0.
REQ-025 rst SHALL take priority over enable and tgt_vld, and reset mid-ramp SHALL abandon the ramp with no residual step.

Structure
REQ-026 The state enum and the default TICK_DIV and STEP constants SHALL live in a shared package, pdm_pkg.
REQ-027 The tick counter SHALL be a separate sub-module, tick_gen, with inputs clk, rst and clr, and output tick.

Verification
Bench parameters: TICK_DIV = 4, STEP = 16'h0100.
REQ-028 Scenario 1: rst held for 2 cycles -> duty = 0, tgt_rdy = 0, at_tgt = 0, busy = 0.
REQ-029 Scenario 2: enable = 1, then target 16'h0300 -> duty goes 0100, 0200, 0300 at 4-cycle spacing; at_tgt = 1 the cycle after 0300 appears.
REQ-030 Scenario 3: from 16'h0300, target 16'h0250 -> a single tick snaps duty to 0250 and busy pulses for one ramp only.
REQ-031 Scenario 4: from 16'hFF80, target 16'hFFFF -> duty = FFFF with no wrap; from 16'h0080, target 0 -> duty = 0000 with no underflow.
REQ-032 Scenario 5: ramping 0 toward 16'h0800, at 0300 retarget to 16'h0100 -> next ticks give 0200 then 0100, then HOLD; also check a target accepted on a tick cycle.
REQ-033 Scenario 6: enable = 0 (and separately rst = 1) mid-ramp at 16'h0400 -> next cycle duty = 0, state IDLE, tgt_rdy = 0.
